// File: rtl/sseg_if.sv
// ---------------------------------------------------------------------------
// sseg_if
// Groups the signals between the reaction-timer control logic and the
// seven-segment scan driver.
//   master : produces the digit codes and display mode, and reads back the
//            display outputs (control FSM / testbench side)
//   slave  : the scan driver itself
// Signals:
//   ltr_flag   1 = letter glyph table, 0 = numeric glyph table
//   digit0..3  4-bit digit codes, digit0 rightmost
//   dp_in      decimal point request per digit, active-high
//   an         anode enables, active-low, bit i = digit i
//   sseg       segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick one-cycle pulse when a new snapshot is taken
// ---------------------------------------------------------------------------
interface sseg_if;
  logic       ltr_flag;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  modport master (
    output ltr_flag, digit0, digit1, digit2, digit3, dp_in,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  ltr_flag, digit0, digit1, digit2, digit3, dp_in,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running N-bit refresh counter splits each frame into four slots.
// The inputs are snapshotted once per frame (at the last counter value) so a
// frame never mixes old and new digits or glyph tables. Each slot starts with
// DEAD_CYC cycles of all anodes off to suppress ghosting. All outputs are
// registered; there is no combinational path from inputs to outputs.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  sseg_if.slave (digit codes, mode, dp requests in; an/sseg/frame_tick out)
// Parameters:
//   N        refresh counter width; slot = 2^(N-2) cycles, frame = 2^N cycles
//   DEAD_CYC dark cycles at the start of each slot, 1 <= DEAD_CYC < 2^(N-2)
// Build option:
//   SSEG_LEADING_ZERO_BLANK_EN  when defined, leading zeros on digit3..digit1
//                               are blanked in numeric mode
// ---------------------------------------------------------------------------
module sseg_scan_driver #(
  parameter int N        = 18,
  parameter int DEAD_CYC = 16
) (
  input  logic   clk,
  input  logic   rst,
  sseg_if.slave  bus
);

  localparam logic [N-3:0] DEAD_L = (N-2)'(DEAD_CYC);

  // Numeric glyph table, bits g..a, active-low
  function automatic logic [6:0] num_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE:
               g = 7'b0111111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Letter glyph table: A -> H, 5 -> I, 0 -> O, everything else blank
  function automatic logic [6:0] ltr_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'hA:    g = 7'b0001001;
      4'h5:    g = 7'b1111001;
      4'h0:    g = 7'b1000000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [N-1:0]     q_r;
  logic [3:0][3:0]  dig_r;
  logic             ltr_r;
  logic [3:0]       dp_r;
  logic [3:0]       an_r;
  logic [7:0]       sseg_r;
  logic             tick_r;

  logic             wrap_s;
  logic [1:0]       slot_s;
  logic [N-3:0]     off_s;
  logic [3:0]       cur_dig_s;
  logic [3:0]       lz_s;
  logic [6:0]       glyph_s;
  logic             dp_bit_s;
  logic [3:0]       an_nxt_s;
  logic [7:0]       sseg_nxt_s;

  assign wrap_s = (q_r == {N{1'b1}});
  assign slot_s = q_r[N-1:N-2];
  assign off_s  = q_r[N-3:0];

  // Refresh counter, free-running and wrapping every frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      q_r <= q_r + N'(1);
    end
  end

  // Frame snapshot: captured on the last count so the new frame sees it from q = 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_r <= {4{4'hF}};
      ltr_r <= 1'b0;
      dp_r  <= 4'b0000;
    end else if (wrap_s) begin
      dig_r <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
      ltr_r <= bus.ltr_flag;
      dp_r  <= bus.dp_in;
    end else begin
      dig_r <= dig_r;
      ltr_r <= ltr_r;
      dp_r  <= dp_r;
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A zero is blanked only while every digit to its left is also blanked
  logic lz3_s;
  logic lz2_s;
  logic lz1_s;
  assign lz3_s = ~ltr_r & (dig_r[3] == 4'h0);
  assign lz2_s = lz3_s & (dig_r[2] == 4'h0);
  assign lz1_s = lz2_s & (dig_r[1] == 4'h0);
  assign lz_s  = {lz3_s, lz2_s, lz1_s, 1'b0};
`else
  assign lz_s  = 4'b0000;
`endif

  // Next-state of the display outputs from the counter and the snapshot
  always_comb begin
    an_nxt_s   = 4'b1111;
    sseg_nxt_s = 8'hFF;
    glyph_s    = 7'b1111111;
    dp_bit_s   = 1'b1;
    cur_dig_s  = dig_r[slot_s];
    if (off_s < DEAD_L) begin
      an_nxt_s   = 4'b1111;
      sseg_nxt_s = 8'hFF;
    end else begin
      an_nxt_s = ~(4'b0001 << slot_s);
      if (lz_s[slot_s]) begin
        glyph_s = 7'b1111111;
      end else if (ltr_r) begin
        glyph_s = ltr_glyph(cur_dig_s);
      end else begin
        glyph_s = num_glyph(cur_dig_s);
      end
      // The blank code never lights its dp; a blanked zero still may
      if (cur_dig_s == 4'hF) begin
        dp_bit_s = 1'b1;
      end else begin
        dp_bit_s = ~dp_r[slot_s];
      end
      sseg_nxt_s = {dp_bit_s, glyph_s};
    end
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r   <= 4'b1111;
      sseg_r <= 8'hFF;
      tick_r <= 1'b0;
    end else begin
      an_r   <= an_nxt_s;
      sseg_r <= sseg_nxt_s;
      tick_r <= wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.sseg       = sseg_r;
  assign bus.frame_tick = tick_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_driver
// Self-checking bench for sseg_scan_driver with N=6, DEAD_CYC=2
// (slot = 16 cycles, frame = 64). A frame-level reference model predicts
// an/sseg/frame_tick every cycle from the display rules; directed scenarios
// add literal expectations for the key glyphs and boundaries.
// ---------------------------------------------------------------------------
module tb_sseg_scan_driver;
  localparam int N     = 6;
  localparam int DEAD  = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sseg_if bus();

  sseg_scan_driver #(.N(N), .DEAD_CYC(DEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_cnt;
  logic [3:0] m_dig [4];
  logic       m_ltr;
  logic [3:0] m_dp;
  int         tick_seen;

  logic [6:0] num_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input int cnt);
    logic [3:0] one;
    one = 4'b0001;
    if ((cnt % SLOT) < DEAD) return 4'b1111;
    return ~(one << (cnt / SLOT));
  endfunction

  function automatic logic [7:0] exp_seg(input int cnt);
    int         slot;
    logic [3:0] code;
    logic       blank;
    logic [6:0] glyph;
    logic       dp;
    slot = cnt / SLOT;
    if ((cnt % SLOT) < DEAD) return 8'hFF;
    code  = m_dig[slot];
    blank = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (!m_ltr && slot >= 1) begin
      blank = 1'b1;
      for (int k = slot; k < 4; k++) if (m_dig[k] != 4'h0) blank = 1'b0;
    end
`endif
    if (blank)                     glyph = 7'h7F;
    else if (!m_ltr)               glyph = num_tab[code];
    else if (code == 4'hA)         glyph = 7'h09;
    else if (code == 4'h5)         glyph = 7'h79;
    else if (code == 4'h0)         glyph = 7'h40;
    else                           glyph = 7'h7F;
    dp = (code == 4'hF) ? 1'b1 : ~m_dp[slot];
    return {dp, glyph};
  endfunction

  function automatic int shown();
    return (m_cnt + FRAME - 1) % FRAME;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 4'hF;
    m_ltr = 1'b0;
    m_dp  = 4'b0000;
  endtask

  // One clock: predict, advance the model, then compare after the edge
  task automatic step();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_tick;
    e_an   = exp_an(m_cnt);
    e_seg  = exp_seg(m_cnt);
    e_tick = (m_cnt == FRAME - 1);
    if (m_cnt == FRAME - 1) begin
      m_dig[0] = bus.digit0;
      m_dig[1] = bus.digit1;
      m_dig[2] = bus.digit2;
      m_dig[3] = bus.digit3;
      m_ltr    = bus.ltr_flag;
      m_dp     = bus.dp_in;
    end
    m_cnt = (m_cnt + 1) % FRAME;
    @(posedge clk);
    #1;
    check_eq("an", {28'd0, bus.an}, {28'd0, e_an});
    check_eq("sseg", {24'd0, bus.sseg}, {24'd0, e_seg});
    check_eq("frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_tick});
    if (bus.frame_tick) tick_seen++;
  endtask

  task automatic run_until_shown(input int x);
    int n;
    n = 0;
    step();
    while (shown() != x && n < 200) begin
      step();
      n++;
    end
    check_eq("reach_slot_pos", shown(), x);
  endtask

  task automatic next_frame();
    step();
    while (m_cnt != 0) step();
  endtask

  task automatic set_inputs(input logic ltr, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dp);
    bus.ltr_flag = ltr;
    bus.digit3   = d3;
    bus.digit2   = d2;
    bus.digit1   = d1;
    bus.digit0   = d0;
    bus.dp_in    = dp;
  endtask

  task automatic set_rand();
    set_inputs(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1'b1;
    set_inputs(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
    model_reset();
    tick_seen = 0;
    #1;
    check_eq("reset_an", {28'd0, bus.an}, 32'h0000000F);
    check_eq("reset_sseg", {24'd0, bus.sseg}, 32'h000000FF);
    check_eq("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
    #11;
    rst = 1'b0;

    // Run a couple of frames with random inputs, then reset mid-frame
    repeat (2 * FRAME) begin
      if ($urandom_range(0, 7) == 0) set_rand();
      step();
    end
    set_rand();
    repeat (23) step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_an", {28'd0, bus.an}, 32'h0000000F);
    check_eq("async_rst_sseg", {24'd0, bus.sseg}, 32'h000000FF);
    check_eq("async_rst_tick", {31'd0, bus.frame_tick}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("held_rst_sseg", {24'd0, bus.sseg}, 32'h000000FF);
    rst = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      check_eq("dark_after_rst", {24'd0, bus.sseg}, 32'h000000FF);
    end
    check_eq("tick_after_release", tick_seen, 1);

    // Letter mode: H I blank blank
    set_inputs(1'b1, 4'hF, 4'hF, 4'h5, 4'hA, 4'b0000);
    next_frame();
    run_until_shown(0);
    check_eq("ltr_dead0_an", {28'd0, bus.an}, 32'h0000000F);
    run_until_shown(1);
    check_eq("ltr_dead1_an", {28'd0, bus.an}, 32'h0000000F);
    run_until_shown(2);
    check_eq("ltr_s0_an", {28'd0, bus.an}, 32'h0000000E);
    check_eq("ltr_s0_H", {24'd0, bus.sseg}, 32'h00000089);
    run_until_shown(17);
    check_eq("ltr_s1_dead_an", {28'd0, bus.an}, 32'h0000000F);
    run_until_shown(18);
    check_eq("ltr_s1_an", {28'd0, bus.an}, 32'h0000000D);
    check_eq("ltr_s1_I", {24'd0, bus.sseg}, 32'h000000F9);
    run_until_shown(40);
    check_eq("ltr_s2_an", {28'd0, bus.an}, 32'h0000000B);
    check_eq("ltr_s2_blank", {24'd0, bus.sseg}, 32'h000000FF);
    run_until_shown(56);
    check_eq("ltr_s3_an", {28'd0, bus.an}, 32'h00000007);
    check_eq("ltr_s3_blank", {24'd0, bus.sseg}, 32'h000000FF);

    // Numeric 1,2,3,4 with dp on digit2; digit0 changes mid-frame
    set_inputs(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 4'b0100);
    next_frame();
    run_until_shown(8);
    check_eq("num_s0_4", {24'd0, bus.sseg}, 32'h00000099);
    run_until_shown(19);
    bus.digit0 = 4'h7;
    bus.ltr_flag = 1'b1;
    run_until_shown(40);
    check_eq("num_s2_dp2", {24'd0, bus.sseg}, 32'h00000024);
    bus.ltr_flag = 1'b0;
    run_until_shown(8);
    check_eq("num_s0_7", {24'd0, bus.sseg}, 32'h000000F8);
    tick_seen = 0;
    repeat (FRAME) step();
    check_eq("tick_per_frame", tick_seen, 1);

    // Leading zeros 0,0,0,5
    set_inputs(1'b0, 4'h0, 4'h0, 4'h0, 4'h5, 4'b0000);
    next_frame();
    run_until_shown(8);
    check_eq("lz_s0_5", {24'd0, bus.sseg}, 32'h00000092);
    for (int s = 1; s < 4; s++) begin
      run_until_shown(s * SLOT + 8);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      check_eq("lz_blank", {24'd0, bus.sseg}, 32'h000000FF);
`else
      check_eq("lz_zero", {24'd0, bus.sseg}, 32'h000000C0);
`endif
    end

    // Dash code on digit1
    set_inputs(1'b0, 4'h1, 4'h2, 4'hB, 4'h0, 4'b0000);
    next_frame();
    run_until_shown(24);
    check_eq("dash_s1", {24'd0, bus.sseg}, 32'h000000BF);

    // Randomized frames with mid-frame input churn
    for (int f = 0; f < 30; f++) begin
      int k;
      set_rand();
      k = $urandom_range(1, FRAME - 1);
      repeat (k) step();
      set_rand();
      repeat (FRAME - k) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
